// File: rtl/mem_arb_ram_if.sv
// rtl/mem_arb_ram_if.sv - request/response bundle shared by the arbitrated RAM and its requesters
interface mem_arb_ram_if #(
    parameter int NUM_CH     = 4,
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 8
);
    logic [NUM_CH-1:0]            req_valid;
    logic [NUM_CH-1:0]            req_ready;
    logic [NUM_CH-1:0]            req_read;
    logic [NUM_CH-1:0]            req_write;
    logic [NUM_CH*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_CH*DATA_WIDTH-1:0] req_data_in;
    logic [NUM_CH-1:0]            rsp_valid;
    logic [DATA_WIDTH-1:0]        rsp_data_out;
    logic                         rsp_err;

    modport master (
        output req_valid, req_read, req_write, req_addr, req_data_in,
        input  req_ready, rsp_valid, rsp_data_out, rsp_err
    );

    modport slave (
        input  req_valid, req_read, req_write, req_addr, req_data_in,
        output req_ready, rsp_valid, rsp_data_out, rsp_err
    );
endinterface

// File: rtl/mem_arb_ram.sv
// rtl/mem_arb_ram.sv - single-port RAM shared by NUM_CH requesters through a round-robin arbiter
module mem_arb_ram #(
    parameter int NUM_CH     = 4,
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_arb_ram_if.slave  bus
);
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [CH_W-1:0]       rr_ptr;
    logic [CH_W-1:0]       gnt_idx;
    logic [CH_W-1:0]       scan_idx;
    logic [NUM_CH-1:0]     grant;
    logic                  gnt_any;
    logic                  xfer;
    logic                  sel_read;
    logic                  sel_write;
    logic                  in_range;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_data;
    logic [MEM_AW-1:0]     mem_idx;

    // Scan from rr_ptr upward with wrap; the first valid channel wins.
    always_comb begin
        grant    = '0;
        gnt_idx  = rr_ptr;
        gnt_any  = 1'b0;
        scan_idx = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            scan_idx = CH_W'((int'(rr_ptr) + i) % NUM_CH);
            if (!gnt_any && bus.req_valid[scan_idx]) begin
                gnt_any         = 1'b1;
                gnt_idx         = scan_idx;
                grant[scan_idx] = 1'b1;
            end
        end
    end

    assign bus.req_ready = rst_n ? grant : '0;
    assign xfer          = rst_n && gnt_any;

    always_comb begin
        sel_read  = bus.req_read[gnt_idx];
        sel_write = bus.req_write[gnt_idx];
        sel_addr  = bus.req_addr[int'(gnt_idx) * ADDR_WIDTH +: ADDR_WIDTH];
        sel_data  = bus.req_data_in[int'(gnt_idx) * DATA_WIDTH +: DATA_WIDTH];
        in_range  = ({1'b0, sel_addr} < DEPTH_L);
        mem_idx   = sel_addr[MEM_AW-1:0];
    end

    // Storage has no reset; out-of-range writes are dropped.
    always_ff @(posedge clk) begin
        if (xfer && sel_write && in_range) begin
            mem[mem_idx] <= sel_data;
        end
    end

    // Read data is sampled before the same-edge write lands (read-before-write).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr           <= '0;
            bus.rsp_valid    <= '0;
            bus.rsp_data_out <= '0;
            bus.rsp_err      <= 1'b0;
        end else begin
            bus.rsp_valid <= '0;
            if (xfer) begin
                rr_ptr <= (gnt_idx == CH_W'(NUM_CH - 1)) ? '0 : gnt_idx + 1'b1;
                if (sel_read) begin
                    bus.rsp_valid    <= grant;
                    bus.rsp_data_out <= in_range ? mem[mem_idx] : '0;
                    bus.rsp_err      <= !in_range;
                end
            end
        end
    end
endmodule

// File: tb/tb_mem_arb_ram.sv
// tb/tb_mem_arb_ram.sv - self-checking bench for mem_arb_ram with a response scoreboard
module tb_mem_arb_ram;
    localparam int NCH = 4;
    localparam int AW  = 5;
    localparam int DW  = 8;
    localparam int DEP = 24;

    logic clk;
    logic rst_n;

    logic [3:0] v;
    logic [3:0] rd;
    logic [3:0] wr;
    logic [AW-1:0] a  [NCH];
    logic [DW-1:0] dt [NCH];

    mem_arb_ram_if #(.NUM_CH(NCH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    mem_arb_ram #(.NUM_CH(NCH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEP)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always_comb begin
        bus.req_valid   = v;
        bus.req_read    = rd;
        bus.req_write   = wr;
        bus.req_addr    = '0;
        bus.req_data_in = '0;
        for (int k = 0; k < NCH; k++) begin
            bus.req_addr[k*AW +: AW]    = a[k];
            bus.req_data_in[k*DW +: DW] = dt[k];
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [3:0] model_grant(input logic [3:0] vv, input int p);
        for (int i = 0; i < NCH; i++) begin
            if (vv[(p + i) % NCH]) return 4'(1 << ((p + i) % NCH));
        end
        return 4'b0000;
    endfunction

    typedef struct {
        int          due;
        logic [3:0]  vmask;
        logic [7:0]  data;
        logic        err;
    } exp_t;

    exp_t       q[$];
    logic [7:0] ref_mem [32];
    int         cyc  = 0;
    int         eptr = 0;
    logic [3:0] pg;
    exp_t       it;
    exp_t       got;

    // Reference model: own round-robin pointer and memory image, predictions queued at transfer.
    always @(posedge clk) begin
        cyc++;
        if (!rst_n) begin
            q.delete();
            eptr = 0;
        end else begin
            pg = model_grant(v, eptr);
            for (int k = 0; k < NCH; k++) begin
                if (pg[k]) begin
                    eptr = (k + 1) % NCH;
                    if (rd[k]) begin
                        it.due   = cyc;
                        it.vmask = 4'(1 << k);
                        it.data  = (a[k] < 5'd24) ? ref_mem[a[k]] : 8'h00;
                        it.err   = (a[k] >= 5'd24);
                        q.push_back(it);
                    end
                    if (wr[k] && a[k] < 5'd24) ref_mem[a[k]] = dt[k];
                end
            end
        end
    end

    always @(negedge clk) begin
        if (v != 4'b0)
            check("grant_model", 32'(bus.req_ready), rst_n ? 32'(model_grant(v, eptr)) : 32'd0);
        if (q.size() > 0 && q[0].due == cyc) begin
            got = q.pop_front();
            check("sb_rsp_valid", 32'(bus.rsp_valid), 32'(got.vmask));
            check("sb_rsp_data", 32'(bus.rsp_data_out), 32'(got.data));
            check("sb_rsp_err", 32'(bus.rsp_err), 32'(got.err));
        end else if (bus.rsp_valid !== 4'b0) begin
            check("unexpected_rsp", 32'(bus.rsp_valid), 32'd0);
        end
    end

    task automatic req(input int ch, input logic r, input logic w, input logic [AW-1:0] ad, input logic [DW-1:0] d);
        v[ch]  = 1'b1;
        rd[ch] = r;
        wr[ch] = w;
        a[ch]  = ad;
        dt[ch] = d;
    endtask

    // Holds requests until granted; n returns the number of cycles used.
    task automatic run_pending(output int n);
        logic [3:0] g;
        n = 0;
        while (v != 4'b0 && n < 40) begin
            @(negedge clk);
            g = bus.req_ready;
            @(posedge clk);
            #1;
            v = v & ~g;
            n++;
        end
        if (v != 4'b0) begin
            check("grant_timeout", 32'(v), 32'd0);
            v = 4'b0;
        end
    endtask

    typedef struct {
        logic [3:0] v;
        logic [3:0] exp;
    } arb_vec_t;

    arb_vec_t tbl [17];
    int       n;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0]  = '{4'b1111, 4'b0001};
        tbl[1]  = '{4'b1111, 4'b0010};
        tbl[2]  = '{4'b1111, 4'b0100};
        tbl[3]  = '{4'b1111, 4'b1000};
        tbl[4]  = '{4'b1111, 4'b0001};
        tbl[5]  = '{4'b1111, 4'b0010};
        tbl[6]  = '{4'b1111, 4'b0100};
        tbl[7]  = '{4'b1111, 4'b1000};
        tbl[8]  = '{4'b1001, 4'b0001};
        tbl[9]  = '{4'b1001, 4'b1000};
        tbl[10] = '{4'b0010, 4'b0010};
        tbl[11] = '{4'b1001, 4'b1000};
        tbl[12] = '{4'b1001, 4'b0001};
        tbl[13] = '{4'b0000, 4'b0000};
        tbl[14] = '{4'b0100, 4'b0100};
        tbl[15] = '{4'b0011, 4'b0001};
        tbl[16] = '{4'b0011, 4'b0010};

        rst_n = 1'b0;
        v  = 4'hf;
        rd = 4'h0;
        wr = 4'h0;
        for (int k = 0; k < NCH; k++) begin
            a[k]  = '0;
            dt[k] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        check("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("reset_rsp_data", 32'(bus.rsp_data_out), 32'd0);
        check("reset_rsp_err", 32'(bus.rsp_err), 32'd0);
        check("reset_ready", 32'(bus.req_ready), 32'd0);
        rst_n = 1'b1;
        v = 4'h0;
        @(negedge clk);
        check("idle_ready", 32'(bus.req_ready), 32'd0);

        // Arbitration table: no-op transfers, so no responses should appear.
        for (int i = 0; i < 17; i++) begin
            @(posedge clk);
            #1;
            v = tbl[i].v;
            @(negedge clk);
            check($sformatf("arb_row%0d", i), 32'(bus.req_ready), 32'(tbl[i].exp));
        end
        @(posedge clk);
        #1;
        v = 4'h0;

        req(1, 1'b0, 1'b1, 5'd5, 8'hA5);
        run_pending(n);
        req(1, 1'b1, 1'b0, 5'd5, 8'h00);
        run_pending(n);
        check("wr_rd_valid", 32'(bus.rsp_valid), 32'h2);
        check("wr_rd_data", 32'(bus.rsp_data_out), 32'hA5);
        check("wr_rd_err", 32'(bus.rsp_err), 32'd0);

        req(0, 1'b0, 1'b1, 5'd3, 8'h11);
        run_pending(n);
        req(2, 1'b1, 1'b1, 5'd3, 8'h22);
        run_pending(n);
        check("rbw_valid", 32'(bus.rsp_valid), 32'h4);
        check("rbw_old_data", 32'(bus.rsp_data_out), 32'h11);
        req(3, 1'b1, 1'b0, 5'd3, 8'h00);
        run_pending(n);
        check("rbw_new_data", 32'(bus.rsp_data_out), 32'h22);
        @(posedge clk);
        #1;
        check("pulse_one_cycle", 32'(bus.rsp_valid), 32'd0);
        check("data_hold", 32'(bus.rsp_data_out), 32'h22);

        req(0, 1'b0, 1'b1, 5'd30, 8'hFF);
        run_pending(n);
        req(0, 1'b1, 1'b0, 5'd30, 8'h00);
        run_pending(n);
        check("oor_valid", 32'(bus.rsp_valid), 32'h1);
        check("oor_data", 32'(bus.rsp_data_out), 32'd0);
        check("oor_err", 32'(bus.rsp_err), 32'd1);

        for (int k = 0; k < NCH; k++) req(k, 1'b0, 1'b1, 5'(10 + k), 8'(8'h30 + k));
        run_pending(n);
        check("b2b_write_cycles", 32'(n), 32'd4);
        for (int k = 0; k < NCH; k++) req(k, 1'b1, 1'b0, 5'(10 + k), 8'h00);
        run_pending(n);
        check("b2b_read_cycles", 32'(n), 32'd4);
        rd = 4'h0;
        wr = 4'h0;

        req(1, 1'b1, 1'b0, 5'd5, 8'h00);
        run_pending(n);
        rst_n = 1'b0;
        req(2, 1'b1, 1'b0, 5'd3, 8'h00);
        @(posedge clk);
        #1;
        check("midrst_valid", 32'(bus.rsp_valid), 32'd0);
        check("midrst_data", 32'(bus.rsp_data_out), 32'd0);
        check("midrst_err", 32'(bus.rsp_err), 32'd0);
        @(posedge clk);
        #1;
        check("midrst_valid2", 32'(bus.rsp_valid), 32'd0);
        rst_n = 1'b1;
        v = 4'h0;

        repeat (3) @(posedge clk);
        #1;
        check("sb_empty", 32'(q.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
